blend_cmd_sequencer: RTL

Upstream feeder for the image blender. It turns a start request plus two independent 8-bit pixel streams into the 18-bit packed command word the blender consumes: {op[1:0], data_a[7:0], data_b[7:0]}. For each frame it issues one SHIFT word, then one WEIGHT word, then exactly FRAME_LEN pixel-pair words. When no pixel pair is available it fills the gap with NOP words.

---
 rtl/blend_pkg.sv | 32 +++
 rtl/blend_cmd_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/blend_pkg.sv
// -----------------------------------------------------------------------------
// blend_pkg
//   Shared definitions for the blender command path.
//   - OP_* opcodes carried in the top two bits of every command word.
//   - CMD_W: width of the packed command word {op[1:0], a[7:0], b[7:0]}.
//   - blend_state_e: sequencer FSM state encoding.
//   - pack_cmd(): builds a command word from opcode and two data bytes.
// -----------------------------------------------------------------------------
package blend_pkg;

    localparam logic [1:0] OP_PIX    = 2'd0;
    localparam logic [1:0] OP_SHIFT  = 2'd1;
    localparam logic [1:0] OP_WEIGHT = 2'd2;
    localparam logic [1:0] OP_NOP    = 2'd3;

    localparam int CMD_W = 18;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_WEIGHT = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } blend_state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0] op,
                                                  input logic [7:0] a,
                                                  input logic [7:0] b);
        return {op, a, b};
    endfunction

endpackage

// File: rtl/blend_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// blend_cmd_sequencer
//   Turns a start request plus two 8-bit pixel streams into the blender's
//   18-bit command words. Per frame: one SHIFT word, one WEIGHT word, then
//   frame_len PIX words; NOP words fill every cycle with nothing to say.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               frame start, honoured only in IDLE
//   cfg_shift/w1/w2     frame configuration, latched on accepted start
//   frame_len           pixel pairs per frame, latched on accepted start
//   px1_*/px2_*         pixel streams (valid/ready)
//   packer              registered command word
//   pkt_valid           packer carries a non-NOP word
//   busy                FSM is outside IDLE
//   done                one-cycle pulse when a frame completes
//   pix_count           pixel pairs issued in the current or last frame
//   state_dbg           current FSM state
//
// Handshake: a stream pixel transfers in a cycle where its valid and ready
// are both high at the rising clock edge. Valid must not depend on ready.
// Both readies are driven from one joint term, so the two streams are
// always consumed together or not at all.
// -----------------------------------------------------------------------------
module blend_cmd_sequencer
    import blend_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] NOP_FILL = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         cfg_shift,
    input  logic [7:0]         cfg_w1,
    input  logic [7:0]         cfg_w2,
    input  logic [CNT_W-1:0]   frame_len,
    input  logic [7:0]         px1_data,
    input  logic               px1_valid,
    output logic               px1_ready,
    input  logic [7:0]         px2_data,
    input  logic               px2_valid,
    output logic               px2_ready,
    output logic [CMD_W-1:0]   packer,
    output logic               pkt_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count,
    output blend_state_e       state_dbg
);

    localparam logic [CMD_W-1:0] NOP_WORD = {OP_NOP, NOP_FILL, NOP_FILL};

    blend_state_e       state_q, state_d;
    logic [CMD_W-1:0]   packer_q, packer_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   pix_count_q, pix_count_d;
    logic [CNT_W-1:0]   frame_len_q, frame_len_d;
    logic [7:0]         cfg_shift_q, cfg_shift_d;
    logic [7:0]         cfg_w1_q, cfg_w1_d;
    logic [7:0]         cfg_w2_q, cfg_w2_d;
    logic               pair_fire;

    // Joint handshake: a pair moves only when both pixels are present.
    assign pair_fire = (state_q == ST_STREAM) && px1_valid && px2_valid;
    assign px1_ready = pair_fire;
    assign px2_ready = pair_fire;

    always_comb begin
        state_d     = state_q;
        packer_d    = NOP_WORD;
        pkt_valid_d = 1'b0;
        done_d      = 1'b0;
        pix_count_d = pix_count_q;
        frame_len_d = frame_len_q;
        cfg_shift_d = cfg_shift_q;
        cfg_w1_d    = cfg_w1_q;
        cfg_w2_d    = cfg_w2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_shift_d = cfg_shift;
                    cfg_w1_d    = cfg_w1;
                    cfg_w2_d    = cfg_w2;
                    frame_len_d = frame_len;
                    pix_count_d = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                packer_d    = pack_cmd(OP_SHIFT, cfg_shift_q, 8'h00);
                pkt_valid_d = 1'b1;
                state_d     = ST_WEIGHT;
            end
            ST_WEIGHT: begin
                packer_d    = pack_cmd(OP_WEIGHT, cfg_w1_q, cfg_w2_q);
                pkt_valid_d = 1'b1;
                state_d     = (frame_len_q == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (pair_fire) begin
                    packer_d    = pack_cmd(OP_PIX, px1_data, px2_data);
                    pkt_valid_d = 1'b1;
                    // Saturate rather than wrap; with frame_len at max the
                    // exit below fires on the same pair anyway.
                    if (pix_count_q != '1) begin
                        pix_count_d = pix_count_q + CNT_W'(1);
                    end
                    // frame_len_q is non-zero here, so the subtraction is safe.
                    if (pix_count_q == frame_len_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            packer_q    <= NOP_WORD;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_count_q <= '0;
            frame_len_q <= '0;
            cfg_shift_q <= '0;
            cfg_w1_q    <= '0;
            cfg_w2_q    <= '0;
        end else begin
            state_q     <= state_d;
            packer_q    <= packer_d;
            pkt_valid_q <= pkt_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_count_q <= pix_count_d;
            frame_len_q <= frame_len_d;
            cfg_shift_q <= cfg_shift_d;
            cfg_w1_q    <= cfg_w1_d;
            cfg_w2_q    <= cfg_w2_d;
        end
    end

    assign packer    = packer_q;
    assign pkt_valid = pkt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_count = pix_count_q;
    assign state_dbg = state_q;

endmodule
